store_unit: RTL

- Opposite direction to the register-load path: drives A, X or Y out to memory for STA/STX/STY-class instructions.
- On a start pulse, latches the source register and operands, then computes the 6502 effective address.
- Runs a memory write cycle with a ready handshake, then pulses done back to the control FSM.
- Sits between the register file (A/X/Y) and the memory bus interface.

---
 rtl/store_pkg.sv | 30 +++
 rtl/store_addr_calc.sv | 31 +++
 rtl/store_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/store_pkg.sv
// Shared encodings for the store path: addressing modes, source select,
// FSM states and the default write-wait limit.
package store_pkg;

   typedef enum logic [1:0] {
      MODE_ZP   = 2'b00,
      MODE_ZPX  = 2'b01,
      MODE_ABS  = 2'b10,
      MODE_ABSX = 2'b11
   } mode_t;

   typedef enum logic [1:0] {
      SRC_A   = 2'b00,
      SRC_X   = 2'b01,
      SRC_Y   = 2'b10,
      SRC_ILL = 2'b11
   } src_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CALC  = 3'd1,
      ST_FIX   = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   // 0 = wait for mem_ready forever
   localparam int DEFAULT_WAIT_LIMIT = 0;

endpackage

// File: rtl/store_addr_calc.sv
// 6502 effective-address generation for store instructions. Also provides
// the uncorrected (no high-byte carry) address shown during the FIX cycle.
module store_addr_calc
   import store_pkg::*;
(
   input  mode_t       mode,
   input  logic [7:0]  op_lo,
   input  logic [7:0]  op_hi,
   input  logic [7:0]  idx,
   output logic [15:0] eff_addr,
   output logic [15:0] fix_addr
);

   logic [7:0]  lo_sum;
   logic [15:0] abs_sum;

   // Page-0 wrap for ZP indexed, full 16-bit wrap for ABS indexed.
   always_comb begin
      lo_sum   = op_lo + idx;
      abs_sum  = {op_hi, op_lo} + {8'h00, idx};
      fix_addr = {op_hi, lo_sum};
      case (mode)
         MODE_ZP:   eff_addr = {8'h00, op_lo};
         MODE_ZPX:  eff_addr = {8'h00, lo_sum};
         MODE_ABS:  eff_addr = {op_hi, op_lo};
         MODE_ABSX: eff_addr = abs_sum;
         default:   eff_addr = 16'h0000;
      endcase
   end

endmodule

// File: rtl/store_unit.sv
// Store path: captures A/X/Y plus operands on start, computes the 6502
// effective address and runs a single memory write with a ready handshake.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start_STORE; illegal src_sel pulses err
// ST_CALC  | effective address computed from latched operands
// ST_FIX   | ABS indexed only: uncorrected address on the bus, WE low
// ST_WRITE | WE high, ADDR/DATA held until mem_ready (or timeout)
// ST_DONE  | one-cycle done pulse
module store_unit
   import store_pkg::*;
#(
   parameter int WAIT_LIMIT = DEFAULT_WAIT_LIMIT,
   parameter int CNT_W      = 8
) (
   input  logic        FSM_Signal,
   input  logic        reset_STORE,
   input  logic        start_STORE,
   input  logic [1:0]  mode,
   input  logic [1:0]  src_sel,
   input  logic        idx_sel,
   input  logic [7:0]  IN_A,
   input  logic [7:0]  IN_X,
   input  logic [7:0]  IN_Y,
   input  logic [7:0]  op_lo,
   input  logic [7:0]  op_hi,
   input  logic        mem_ready,
   output logic [15:0] ADDR_OUT,
   output logic [7:0]  DATA_OUT,
   output logic        WE,
   output logic        busy,
   output logic        done,
   output logic        err
);

   state_t           state, state_nxt;
   mode_t            mode_q;
   logic [7:0]       src_q, idx_q, lo_q, hi_q;
   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;
   logic             load, err_set;
   logic [7:0]       src_val, idx_val;
   logic [15:0]      eff_addr, fix_addr;

   store_addr_calc u_addr (
      .mode     (mode_q),
      .op_lo    (lo_q),
      .op_hi    (hi_q),
      .idx      (idx_q),
      .eff_addr (eff_addr),
      .fix_addr (fix_addr)
   );

   // Source and index selection from the live register values.
   always_comb begin
      case (src_t'(src_sel))
         SRC_X:   src_val = IN_X;
         SRC_Y:   src_val = IN_Y;
         default: src_val = IN_A;
      endcase
      idx_val = idx_sel ? IN_Y : IN_X;
   end

   // Next-state logic; the wait counter's terminal count triggers the timeout.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      err_set   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_STORE) begin
               if (src_t'(src_sel) == SRC_ILL) begin
                  err_set = 1'b1;
               end else begin
                  load      = 1'b1;
                  state_nxt = ST_CALC;
               end
            end
         end
         ST_CALC:  state_nxt = (mode_q == MODE_ABSX) ? ST_FIX : ST_WRITE;
         ST_FIX:   state_nxt = ST_WRITE;
         ST_WRITE: begin
            if (mem_ready) begin
               state_nxt = ST_DONE;
            end else if ((WAIT_LIMIT > 0) && (wait_cnt == CNT_W'(1))) begin
               state_nxt = ST_IDLE;
               err_set   = 1'b1;
            end
         end
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register, operand capture, wait down-counter and err pulse.
   always_ff @(negedge FSM_Signal or posedge reset_STORE) begin
      if (reset_STORE) begin
         state    <= ST_IDLE;
         mode_q   <= MODE_ZP;
         src_q    <= 8'h00;
         idx_q    <= 8'h00;
         lo_q     <= 8'h00;
         hi_q     <= 8'h00;
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         state <= state_nxt;
         err_q <= err_set;
         if (load) begin
            mode_q <= mode_t'(mode);
            src_q  <= src_val;
            idx_q  <= idx_val;
            lo_q   <= op_lo;
            hi_q   <= op_hi;
         end
         if ((state_nxt == ST_WRITE) && (state != ST_WRITE)) begin
            wait_cnt <= CNT_W'(WAIT_LIMIT);
         end else if ((state == ST_WRITE) && !mem_ready && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
         end
      end
   end

   // Outputs decode from state and the latched operands, so reset clears them at once.
   always_comb begin
      ADDR_OUT = (state == ST_FIX) ? fix_addr : eff_addr;
      DATA_OUT = src_q;
      WE       = (state == ST_WRITE);
      busy     = (state != ST_IDLE);
      done     = (state == ST_DONE);
      err      = err_q;
   end

endmodule
